// File: rtl/face_result_buffer_if.sv
// Detection result stream between the buffer and the result transmitter.
// Valid/ready handshake carrying one buffered detection per beat.
interface face_result_buffer_if #(
    parameter int COORD_W = 32,
    parameter int PYR_W   = 4
);
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic [PYR_W-1:0]   out_pyr;
    logic               out_last;

    modport master (
        output out_valid, out_row, out_col, out_pyr, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row, out_col, out_pyr, out_last,
        output out_ready
    );
endinterface

// File: rtl/face_result_buffer.sv
// Buffers face detections of one image pass, keeps per-level hit and
// drop counters, then drains the detections over a valid/ready stream.
module face_result_buffer #(
    parameter int COORD_W = 32,
    parameter int PYR_W   = 4,
    parameter int DEPTH   = 16,
    parameter int NUM_PYR = 10,
    parameter int CNT_W   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic                          frame_done,
    input  logic                          face_coords_ready,
    input  logic [1:0][COORD_W-1:0]       face_coords,
    input  logic [PYR_W-1:0]              pyramid_number,
    face_result_buffer_if.master          stream,
    output logic [$clog2(DEPTH):0]        fill_count,
    output logic [CNT_W-1:0]              drop_count,
    input  logic [PYR_W-1:0]              level_sel,
    output logic [CNT_W-1:0]              level_hits,
    output logic                          drain_done,
    output logic                          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [PYR_W:0] NPYR = (PYR_W + 1)'(NUM_PYR);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        logic [PYR_W-1:0]   pyr;
    } entry_t;

    state_t          state;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNT_W-1:0] hits [NUM_PYR];

    logic            full;
    logic            empty;
    logic            strobe;
    logic            push;
    logic            drop;
    logic            pop;
    logic            hit_inc;
    logic            sel_in;
    logic [CNT_W-1:0] hits_sel;
    logic [CNT_W-1:0] level_next;

    // Head of the FIFO is always presented; valid only while draining.
    assign stream.out_row   = mem[rd_ptr].row;
    assign stream.out_col   = mem[rd_ptr].col;
    assign stream.out_pyr   = mem[rd_ptr].pyr;
    assign stream.out_valid = (state == DRAIN) && !empty;
    assign stream.out_last  = stream.out_valid && (fill_count == FW'(1));

    // Per-cycle push/pop/count decisions; a new pass start overrides all.
    always_comb begin
        full     = fill_count == FW'(DEPTH);
        empty    = fill_count == '0;
        strobe   = face_coords_ready && (state == COLLECT) && !frame_start;
        push     = strobe && !full;
        drop     = strobe && full;
        pop      = stream.out_valid && stream.out_ready && !frame_start;
        hit_inc  = strobe && ({1'b0, pyramid_number} < NPYR);
        sel_in   = {1'b0, level_sel} < NPYR;
        hits_sel = sel_in ? hits[level_sel] : '0;
        level_next = hits_sel;
        if (sel_in && hit_inc && (pyramid_number == level_sel)
            && (hits_sel != '1)) begin
            level_next = hits_sel + CNT_W'(1);
        end
    end

    // Pass control FSM together with FIFO, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            drop_count <= '0;
            level_hits <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int i = 0; i < NUM_PYR; i++) hits[i] <= '0;
        end else if (frame_start) begin
            state      <= COLLECT;
            busy       <= 1'b1;
            drain_done <= 1'b0;
            rd_ptr     <= wr_ptr;
            fill_count <= '0;
            drop_count <= '0;
            level_hits <= '0;
            for (int i = 0; i < NUM_PYR; i++) hits[i] <= '0;
        end else begin
            drain_done <= 1'b0;
            level_hits <= level_next;
            unique case (state)
                IDLE: ;
                COLLECT: begin
                    if (frame_done) begin
                        state      <= DRAIN;
                        drain_done <= empty && !push;
                    end
                end
                DRAIN: begin
                    drain_done <= pop && (fill_count == FW'(1));
                    if (empty) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                mem[wr_ptr] <= '{row: face_coords[0],
                                 col: face_coords[1],
                                 pyr: pyramid_number};
                wr_ptr      <= wr_ptr + AW'(1);
                fill_count  <= fill_count + FW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                fill_count <= fill_count - FW'(1);
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (hit_inc && (hits[pyramid_number] != '1)) begin
                hits[pyramid_number] <= hits[pyramid_number] + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/face_result_buffer.md
# face_result_buffer

Collects face detections from the Viola-Jones pipeline during one laptop-image pass. Each `face_coords_ready` pulse is tagged with the current `pyramid_number` and written into a parametrised FIFO; per-pyramid-level hit counters and a drop counter are kept alongside. Once the pass ends, the buffered detections are drained over a valid/ready stream to the host-side result path, which replaces printing detections from a bench. The block sits between `top`'s detection outputs and the result transmitter.

## Interface
- `COORD_W`, 32, width of each row/column coordinate.
- `PYR_W`, 4, width of `pyramid_number`.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `NUM_PYR`, 10, number of pyramid levels with hit counters; at most 2^PYR_W.
- `CNT_W`, 16, width of hit and drop counters.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; begins a new collection pass.
- `frame_done` in 1: one-cycle pulse; detection pass complete.
- `face_coords_ready` in 1: one-cycle detection strobe.
- `face_coords` in 2×COORD_W: [0] = row, [1] = column.
- `pyramid_number` in PYR_W: pyramid level of the current detection.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head entry.
- `out_row`, `out_col` out COORD_W: head entry coordinates.
- `out_pyr` out PYR_W: head entry pyramid level.
- `out_last` out 1: head entry is the final entry of the pass.
- `fill_count` out log2(DEPTH)+1: FIFO occupancy.
- `drop_count` out CNT_W: detections lost because the FIFO was full (saturating).
- `level_sel` in PYR_W: selects a hit counter.
- `level_hits` out CNT_W: registered hit count for `level_sel`.
- `drain_done` out 1: one-cycle pulse when the drain completes.
- `busy` out 1: high in COLLECT or DRAIN.

## Operation
- States:
  - IDLE (reset state).
  - COLLECT.
  - DRAIN.
- IDLE:
  - `frame_start` → COLLECT.
  - On entry to COLLECT: FIFO flushed, `drop_count` cleared, all hit counters cleared.
  - Strobes and `frame_done` are ignored.
- COLLECT:
  - `face_coords_ready` with FIFO not full: push {row, col, pyr}.
  - `face_coords_ready` with FIFO full: entry discarded, `drop_count` +1, saturating at 2^CNT_W−1.
  - Every strobe, pushed or dropped, increments `hits[pyramid_number]` (saturating) when `pyramid_number` < NUM_PYR. Out-of-range levels are still pushed but are not counted.
  - `frame_done` → DRAIN. If a strobe arrives on the same cycle, the strobe is processed first.
- DRAIN:
  - `out_valid` = FIFO not empty.
  - A pop occurs on `out_valid` && `out_ready`.
  - `out_last` = `out_valid` && (`fill_count` == 1).
  - Strobes are ignored and do not count as drops.
  - FIFO empty → IDLE with `drain_done` pulsed. This includes a pass with zero detections.
- `frame_start` in COLLECT or DRAIN aborts the pass:
  - flush, clear counters, go to COLLECT;
  - no `drain_done` is pulsed;
  - entries not yet accepted are lost.
- `frame_start` and `frame_done` on the same cycle: `frame_start` wins.
- Circular FIFO: pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty is determined from `fill_count`.
- `out_row`, `out_col`, `out_pyr` are driven from the FIFO head at all times; their value is meaningful only while `out_valid` is high.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE and every output 0, including `out_*`, `fill_count`, `drop_count`, `level_hits`, `drain_done`, `busy`. Pointers, counters and memory contents are also zeroed.
- Push: a strobe sampled at edge N is reflected in `fill_count` after edge N.
- `frame_done` sampled at edge N: state is DRAIN after N, and `out_valid` is high in cycle N+1 if the FIFO is non-empty.
- Drain throughput: one entry per cycle while `out_ready` is held high.
- Pop at edge M of the last entry: `drain_done` is high during cycle M+1; state is IDLE after M+1.
- Empty pass: `frame_done` at N, `drain_done` high during cycle N+1.
- `level_hits` is registered: `level_sel` sampled at edge N appears after N, and includes any increment made at N.
- `out_valid` must not drop while DRAIN holds a non-empty FIFO and `out_ready` is low. Head data stays stable until the pop.

## Test plan
- Reset mid-drain (DEPTH=16): assert `reset_n`=0 with 3 entries buffered → all outputs 0 immediately, without waiting for a clock edge. After release: `busy`=0 and `fill_count`=0.
- Basic pass, 3 strobes:
  - stimulus: (r5,c7,p0), (r20,c40,p2), (r20,c44,p2), then `frame_done`, `out_ready`=1;
  - response: 3 beats in order, `out_last` on the third only, `drain_done` one cycle later;
  - `level_sel`=2 → `level_hits`=2.
- Overflow: 20 strobes into DEPTH=16 → `fill_count`=16, `drop_count`=4. The drain returns the first 16 entries in order.
- Backpressure: `out_ready` toggles 1,0,0,1 during the drain → `out_valid` stays high, and head data is held during the 0-cycles.
- Boundary cases:
  - `frame_done` with no strobes → `drain_done` exactly 1 cycle later, `out_valid` never high;
  - strobe coincident with `frame_done` → that strobe is pushed;
  - `pyramid_number`=12 → entry pushed, no counter changes.
- Abort: `frame_start` mid-DRAIN with 5 entries left → `fill_count`=0 and `drop_count`=0 next cycle, state COLLECT, no `drain_done`. Wrap-around is checked across two passes of 12 entries each, covering more than DEPTH pushes in total.
